// File: rtl/divider_unit_pkg.sv
// Shared definitions for the iterative RISC-V M-extension divide/remainder unit.
// Holds the instruction decode constants, the accuracy_control field layout and
// the controller state encoding used by divider_unit.
package divider_unit_pkg;

  // Instruction decode
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // accuracy_control layout: [0] approximation enable, [2:1] mode (only 00
  // exists, so the field is ignored), [10:3] per-position trial mask.
  localparam int ACC_EN_BIT   = 0;
  localparam int ACC_MASK_LSB = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/divider_unit_div_restoring_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_in   - partial remainder entering this step
//   divisor  - divisor magnitude
//   dvd_bit  - next dividend bit shifted into the remainder
//   en       - trial subtraction allowed for this quotient position
//   rem_out  - partial remainder leaving this step
//   q_bit    - quotient bit produced by this step
// The remainder path is wider than the divisor because suppressed trials let
// the partial remainder grow past the divisor for a few positions.
module divider_unit_div_restoring_step #(
  parameter int W  = 41,
  parameter int DW = 32
) (
  input  logic [W-1:0]  rem_in,
  input  logic [DW-1:0] divisor,
  input  logic          dvd_bit,
  input  logic          en,
  output logic [W-1:0]  rem_out,
  output logic          q_bit
);

  logic [W-1:0] shifted;
  logic [W-1:0] dvs_ext;
  logic         unused_top;

  // The top remainder bit is headroom only; the caller guarantees it is zero.
  assign unused_top = rem_in[W-1];
  assign shifted    = {rem_in[W-2:0], dvd_bit};
  assign dvs_ext    = {{(W-DW){1'b0}}, divisor};

  always_comb begin
    q_bit   = en && (shifted >= dvs_ext);
    rem_out = q_bit ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/divider_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit, one quotient bit per cycle, with an
// optional run-time approximation that suppresses trial subtractions on the
// low APX_BITS quotient positions selected by a mask.
// Ports:
//   CLK              - rising-edge clock
//   reset            - synchronous, active-high reset
//   opcode/funct7/funct3 - instruction fields used to detect a request
//   accuracy_control - [0] approx enable, [10:3] trial mask, rest ignored
//   rs1 / rs2        - dividend / divisor
//   div_unit_busy    - stall request while a division is pending
//   div_output       - registered quotient or remainder
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int APX_BITS = 8
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [31:0]     accuracy_control,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            div_unit_busy,
  output logic [XLEN-1:0] div_output
);

  // Remainder headroom: APX_BITS un-subtracted doublings plus one guard bit.
  localparam int RW = XLEN + APX_BITS + 1;
  localparam int CW = $clog2(XLEN);
  localparam int MW = $clog2(APX_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(XLEN - 1);
  localparam logic [CW-1:0] APX_LIMIT = CW'(APX_BITS);

  state_t state, state_next;

  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     dvd_q;
  logic [XLEN-1:0]     dvs_q;
  logic [XLEN-1:0]     rs1_q;
  logic [XLEN-1:0]     quo_q;
  logic [RW-1:0]       rem_q;
  logic                is_rem_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic                apx_en_q;
  logic [APX_BITS-1:0] mask_q;

  logic                request;
  logic                is_signed;
  logic                is_rem;
  logic                rs1_neg;
  logic                rs2_neg;
  logic                trial_en;
  logic [RW-1:0]       rem_nx;
  logic                q_bit;
  logic                last_step;
  logic                div_zero;
  logic [XLEN-1:0]     quo_mag;
  logic [XLEN-1:0]     quo_res;
  logic [XLEN-1:0]     rem_res;
  logic                unused_acc;

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v,
                                                  input logic            neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign unused_acc = ^{accuracy_control[31:ACC_MASK_LSB+APX_BITS],
                        accuracy_control[ACC_MASK_LSB-1:ACC_EN_BIT+1]};

  assign request   = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && funct3[2];
  assign is_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign is_rem    = (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign rs1_neg   = rs1[XLEN-1];
  assign rs2_neg   = rs2[XLEN-1];

  // A trial is skipped only for a masked-off low position in approximate mode.
  assign trial_en  = !(apx_en_q && (cnt_q < APX_LIMIT) && !mask_q[cnt_q[MW-1:0]]);
  assign last_step = (cnt_q == '0);

  divider_unit_div_restoring_step #(
    .W  (RW),
    .DW (XLEN)
  ) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .dvd_bit (dvd_q[cnt_q]),
    .en      (trial_en),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // Bit 0 of quo_q is still clear on the last step, so OR-ing in q_bit
  // forms the final quotient magnitude.
  assign quo_mag  = quo_q | XLEN'(q_bit);
  assign div_zero = (dvs_q == '0);
  assign quo_res  = div_zero ? '1    : cond_negate(quo_mag, q_neg_q);
  assign rem_res  = div_zero ? rs1_q : cond_negate(rem_nx[XLEN-1:0], r_neg_q);

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    div_unit_busy = 1'b0;
    case (state)
      IDLE: begin
        div_unit_busy = request;
        if (request) state_next = BUSY;
      end
      BUSY: begin
        div_unit_busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture in IDLE, one restoring step per BUSY cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rs1_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      is_rem_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      apx_en_q   <= 1'b0;
      mask_q     <= '0;
      div_output <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            dvd_q    <= cond_negate(rs1, is_signed && rs1_neg);
            dvs_q    <= cond_negate(rs2, is_signed && rs2_neg);
            rs1_q    <= rs1;
            is_rem_q <= is_rem;
            q_neg_q  <= is_signed && (rs1_neg ^ rs2_neg);
            r_neg_q  <= is_signed && rs1_neg;
            apx_en_q <= accuracy_control[ACC_EN_BIT];
            mask_q   <= accuracy_control[ACC_MASK_LSB +: APX_BITS];
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= CNT_LAST;
          end
        end
        BUSY: begin
          rem_q        <= rem_nx;
          quo_q[cnt_q] <= q_bit;
          cnt_q        <= cnt_q - 1'b1;
          // Result registered on entry to DONE so it is valid while busy is low.
          if (last_step) div_output <= is_rem_q ? rem_res : quo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
module tb_divider_unit;

  localparam logic [6:0] OP_CODE = 7'b0110011;
  localparam logic [6:0] MULDIV  = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] accuracy_control;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        div_unit_busy;
  logic [31:0] div_output;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divider_unit dut (
    .CLK              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .funct7           (funct7),
    .funct3           (funct3),
    .accuracy_control (accuracy_control),
    .rs1              (rs1),
    .rs2              (rs2),
    .div_unit_busy    (div_unit_busy),
    .div_output       (div_output)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;
    logic [31:0] exp;
  } vec_t;

  // Reference: plain integer division; in approximate mode the high part is an
  // exact divide and the low positions are walked with masked trials.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] acc);
    logic              sgn;
    logic [31:0]       ma, mb, qs, rs;
    longint unsigned   q, r;
    sgn = !f3[0];
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = longint'(ma) / longint'(mb);
    r  = longint'(ma) % longint'(mb);
    if (acc[0]) begin
      q = longint'(ma >> 8) / longint'(mb);
      r = longint'(ma >> 8) % longint'(mb);
      for (int i = 7; i >= 0; i--) begin
        r = r * 2 + longint'(ma[i]);
        q = q * 2;
        if (acc[3+i] && r >= longint'(mb)) begin
          r = r - longint'(mb);
          q = q + 1;
        end
      end
    end
    qs = q[31:0];
    rs = r[31:0];
    if (sgn && (a[31] ^ b[31])) qs = -qs;
    if (sgn && a[31])           rs = -rs;
    return f3[1] ? rs : qs;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] acc);
    opcode           = OP_CODE;
    funct7           = MULDIV;
    funct3           = f3;
    rs1              = a;
    rs2              = b;
    accuracy_control = acc;
  endtask

  // Counts busy cycles at negedges until busy drops; result sampled then.
  task automatic wait_result(output logic [31:0] res, output int cyc, input bit scramble);
    cyc = 0;
    res = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!div_unit_busy) begin
        res = div_output;
        return;
      end
      cyc++;
      if (scramble && c == 1) begin
        rs1              = $urandom;
        rs2              = $urandom;
        accuracy_control = $urandom;
        funct3           = 3'($urandom);
      end
    end
    res = div_output;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    opcode           = 7'd0;
    funct7           = 7'd0;
    funct3           = 3'd0;
    rs1              = 32'd0;
    rs2              = 32'd0;
    accuracy_control = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (div_unit_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", div_unit_busy);
    end
    checks++;
    if (div_output !== 32'd0) begin
      failures++;
      $display("FAIL reset_output: got %h expected 00000000", div_output);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t        v[$];
    logic [31:0] res;
    int          cyc;
    v.push_back('{"div_400_20",       3'b100, 32'd400,       32'd20,        32'b11111111_001, 32'd20});
    v.push_back('{"div_apx_100_20",   3'b100, 32'd100,       32'd20,        32'b11111000_001, 32'd0});
    v.push_back('{"remu_535_20",      3'b111, 32'd535,       32'd20,        32'b11111111_001, 32'd15});
    v.push_back('{"remu_535_500",     3'b111, 32'd535,       32'd500,       32'b11111111_001, 32'd35});
    v.push_back('{"remu_apx_535_500", 3'b111, 32'd535,       32'd500,       32'b11111000_001, 32'd535});
    v.push_back('{"div_m7_2",         3'b100, 32'hFFFF_FFF9, 32'd2,         32'd0,            32'hFFFF_FFFD});
    v.push_back('{"rem_m7_2",         3'b110, 32'hFFFF_FFF9, 32'd2,         32'd0,            32'hFFFF_FFFF});
    v.push_back('{"div_by_zero",      3'b100, 32'd12345,     32'd0,         32'd0,            32'hFFFF_FFFF});
    v.push_back('{"rem_9_by_zero",    3'b110, 32'd9,         32'd0,         32'd0,            32'd9});
    v.push_back('{"divu_apx_by_zero", 3'b101, 32'd77,        32'd0,         32'b00000000_001, 32'hFFFF_FFFF});
    v.push_back('{"div_overflow",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,            32'h8000_0000});
    v.push_back('{"rem_overflow",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,            32'd0});
    foreach (v[i]) begin
      @(posedge clk);
      #1 drive(v[i].f3, v[i].a, v[i].b, v[i].acc);
      wait_result(res, cyc, 1'b0);
      opcode = 7'd0;
      checks++;
      if (cyc !== 33) begin
        failures++;
        $display("FAIL %s_latency: got %0d busy cycles expected 33", v[i].name, cyc);
      end
      checks++;
      if (res !== v[i].exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", v[i].name, res, v[i].exp);
      end
    end
  endtask

  task automatic test_non_request();
    logic [31:0] held;
    held = div_output;
    @(posedge clk);
    #1 drive(3'b001, 32'd50, 32'd5, 32'd0);
    @(negedge clk);
    checks++;
    if (div_unit_busy !== 1'b0) begin
      failures++;
      $display("FAIL nonreq_mul_busy: got %b expected 0", div_unit_busy);
    end
    @(posedge clk);
    #1 begin
      drive(3'b100, 32'd50, 32'd5, 32'd0);
      opcode = 7'b0010011;
    end
    @(negedge clk);
    checks++;
    if (div_unit_busy !== 1'b0) begin
      failures++;
      $display("FAIL nonreq_opcode_busy: got %b expected 0", div_unit_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (div_output !== held) begin
      failures++;
      $display("FAIL nonreq_hold: got %h expected %h", div_output, held);
    end
    opcode = 7'd0;
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, acc, exp, res;
    int          cyc;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(4, 7));
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = $urandom;
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 8);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      a = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0:       acc = $urandom & 32'hFFFF_FFFE;
        1:       acc = $urandom | 32'h0000_07F9;
        default: acc = $urandom | 32'h0000_0001;
      endcase
      exp = model(f3, a, b, acc);
      @(posedge clk);
      #1 drive(f3, a, b, acc);
      wait_result(res, cyc, n[0]);
      opcode = 7'd0;
      checks++;
      if (cyc !== 33) begin
        failures++;
        $display("FAIL rand%0d_latency: got %0d busy cycles expected 33", n, cyc);
      end
      checks++;
      if (res !== exp) begin
        failures++;
        $display("FAIL rand%0d f3=%b a=%h b=%h acc=%h: got %h expected %h",
                 n, f3, a, b, acc, res, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res_a, res_b, exp_a, exp_b;
    int          cyc;
    exp_a = model(3'b101, 32'd1000, 32'd7, 32'd0);
    exp_b = model(3'b110, 32'hFFFF_FF9C, 32'd7, 32'd0);
    @(posedge clk);
    #1 drive(3'b101, 32'd1000, 32'd7, 32'd0);
    wait_result(res_a, cyc, 1'b0);
    checks++;
    if (res_a !== exp_a) begin
      failures++;
      $display("FAIL b2b_first: got %h expected %h", res_a, exp_a);
    end
    drive(3'b110, 32'hFFFF_FF9C, 32'd7, 32'd0);
    @(negedge clk);
    checks++;
    if (div_unit_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart_busy: got %b expected 1", div_unit_busy);
    end
    checks++;
    if (div_output !== exp_a) begin
      failures++;
      $display("FAIL b2b_output_hold: got %h expected %h", div_output, exp_a);
    end
    wait_result(res_b, cyc, 1'b0);
    opcode = 7'd0;
    checks++;
    if (cyc !== 32) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d busy cycles expected 32", cyc);
    end
    checks++;
    if (res_b !== exp_b) begin
      failures++;
      $display("FAIL b2b_second: got %h expected %h", res_b, exp_b);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int          cyc;
    @(posedge clk);
    #1 drive(3'b101, 32'hFFFF_FFFF, 32'd3, 32'd0);
    repeat (10) @(negedge clk);
    reset  = 1'b1;
    opcode = 7'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (div_unit_busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_busy: got %b expected 0", div_unit_busy);
    end
    checks++;
    if (div_output !== 32'd0) begin
      failures++;
      $display("FAIL midreset_output: got %h expected 00000000", div_output);
    end
    @(posedge clk);
    #1 drive(3'b100, 32'hFFFF_FFF9, 32'd2, 32'd0);
    wait_result(res, cyc, 1'b0);
    opcode = 7'd0;
    checks++;
    if (cyc !== 33) begin
      failures++;
      $display("FAIL midreset_next_latency: got %0d busy cycles expected 33", cyc);
    end
    checks++;
    if (res !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL midreset_next_result: got %h expected fffffffd", res);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_non_request();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
